// File: rtl/morse_timer_arbiter_if.sv
// morse_timer_arbiter_if: request/status bundle between game controller (master) and slot/round timer (slave)
//   req[3]       level slot requests          game_en   round active
//   pause        freeze request               grant[3]  one-hot slot timer owner
//   done[3]      per-slot expiry flag         busy      slot timer in RUN or HOLD
//   timeout      round time expired           secs_left[6] remaining round seconds
interface morse_timer_arbiter_if;
    logic [2:0] req;
    logic       game_en;
    logic       pause;
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic       timeout;
    logic [5:0] secs_left;
    modport master (output req, game_en, pause, input grant, done, busy, timeout, secs_left);
    modport slave  (input req, game_en, pause, output grant, done, busy, timeout, secs_left);
endinterface

// File: rtl/morse_timer_arbiter.sv
// morse_timer_arbiter: shared 3-requester slot timer with fixed-priority arbitration plus an independent round timer
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   bus (slave)   req/game_en/pause in; grant/done/busy/timeout/secs_left out
//   Build option TIMER_PAUSE_EN: pause freezes slot counter, game prescaler and secs_left;
//   when undefined the pause input is present but ignored.
module morse_timer_arbiter #(
    parameter int PRESCALE = 50000000,
    parameter int SLOT_SEC = 3,
    parameter int GAME_SEC = 60
) (
    input logic clk,
    input logic rst,
    morse_timer_arbiter_if.slave bus
);
    localparam int SLOT_CYCLES = PRESCALE * SLOT_SEC;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    gnt_q, gnt_d, done_q, done_d, pick;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    secs_q, secs_d;
    logic          to_q, to_d, paused, owner_req;

`ifdef TIMER_PAUSE_EN
    assign paused = bus.pause;
`else
    logic unused_pause;
    assign unused_pause = bus.pause;
    assign paused = 1'b0;
`endif

    assign pick = bus.req[0] ? 3'b001 : bus.req[1] ? 3'b010 : bus.req[2] ? 3'b100 : 3'b000;
    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                gnt_d  = pick;
                done_d = 3'b000;
                cnt_d  = (|bus.req) ? CW'(SLOT_CYCLES - 1) : '0;
                state_d = (|bus.req) ? RUN : IDLE;
            end
            RUN: begin
                // abort wins over expiry and over pause
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    cnt_d   = '0;
                end else if (!paused) begin
                    if (cnt_q == '0) begin
                        done_d  = gnt_q;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    done_d  = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                done_d  = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    // secs_left==0 with timeout low marks an unloaded round
    always_comb begin
        pre_d  = pre_q;
        secs_d = secs_q;
        to_d   = to_q;
        if (!bus.game_en) begin
            pre_d  = '0;
            secs_d = '0;
            to_d   = 1'b0;
        end else if (!to_q && secs_q == '0) begin
            pre_d  = '0;
            secs_d = 6'(GAME_SEC);
        end else if (!to_q && !paused) begin
            if (pre_q == PW'(PRESCALE - 1)) begin
                pre_d  = '0;
                secs_d = secs_q - 1'b1;
                to_d   = (secs_q == 6'd1);
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            pre_q   <= '0;
            secs_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            secs_q  <= secs_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant     = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.timeout   = to_q;
    assign bus.secs_left = secs_q;
endmodule
